// File: rtl/hssi_mb_responder.sv
// hssi_mb_responder: CSR mailbox that turns CMD writes into single
// read/write requests on the traffic-controller register port.
// Optional feature macro: HSSI_MB_TIMEOUT_EN (read-response timeout).
module hssi_mb_responder #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_wr,
  input  logic              csr_rd,
  input  logic [3:0]        csr_addr,
  input  logic [31:0]       csr_wdata,
  output logic [31:0]       csr_rdata,
  output logic              csr_rdata_vld,
  output logic [ADDR_W-1:0] tc_addr,
  output logic              tc_wr,
  output logic              tc_rd,
  output logic [31:0]       tc_wdata,
  input  logic              tc_waitrequest,
  input  logic [31:0]       tc_rdata,
  input  logic              tc_rdata_vld
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  localparam logic [3:0]  OFS_CMD     = 4'h0;
  localparam logic [3:0]  OFS_ADDRESS = 4'h4;
  localparam logic [3:0]  OFS_RDDATA  = 4'h8;
  localparam logic [3:0]  OFS_WRDATA  = 4'hC;
  localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF;

  if (ADDR_W < 1 || ADDR_W > 32 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("hssi_mb_responder: unsupported ADDR_W/TIMEOUT_CYCLES");
  end

  state_t      state, state_next;
  logic [31:0] addr_reg, wdata_reg, rddata_reg;
  logic        ack, err, op_rd;
  logic        busy;
  logic        cmd_wr, cmd_rd_go, cmd_wr_go, cmd_bad;
  logic        accept, rd_capture, timeout;
  logic [31:0] cmd_view;

  // Command decode: CMD is only accepted while idle.
  assign cmd_wr     = csr_wr && (csr_addr == OFS_CMD) && (state == IDLE);
  assign cmd_rd_go  = cmd_wr && (csr_wdata[1:0] == 2'b01);
  assign cmd_wr_go  = cmd_wr && (csr_wdata[1:0] == 2'b10);
  assign cmd_bad    = cmd_wr && (csr_wdata[1:0] == 2'b11);
  assign accept     = (state == ISSUE) && !tc_waitrequest;
  assign rd_capture = (state == WAIT_RD) && tc_rdata_vld;

`ifdef HSSI_MB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             counting;

  assign counting = ((state == ISSUE) && op_rd) || (state == WAIT_RD);
  assign timeout  = counting && !rd_capture &&
                    (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Read timeout counter: runs only while a read is outstanding.
  always_ff @(posedge clk) begin
    if (rst || !counting) to_cnt <= '0;
    else                  to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_rd_go || cmd_wr_go) state_next = ISSUE;
      ISSUE: begin
        if (timeout)     state_next = DONE;
        else if (accept) state_next = op_rd ? WAIT_RD : DONE;
      end
      WAIT_RD: if (rd_capture || timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; request fields come from frozen registers.
  always_comb begin
    busy     = (state == ISSUE) || (state == WAIT_RD);
    tc_wr    = (state == ISSUE) && !op_rd;
    tc_rd    = (state == ISSUE) && op_rd;
    tc_addr  = addr_reg[ADDR_W-1:0];
    tc_wdata = wdata_reg;
    cmd_view = {27'b0, err, busy, ack, tc_wr, tc_rd};
  end

  // ADDRESS/WRDATA registers: writable whenever no request is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (csr_wr && !busy) begin
      if (csr_addr == OFS_ADDRESS) addr_reg  <= csr_wdata;
      if (csr_addr == OFS_WRDATA)  wdata_reg <= csr_wdata;
    end
  end

  // Command status: op type, ACK and ERR. Command 11 completes at once with error.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_rd <= 1'b0;
      ack   <= 1'b0;
      err   <= 1'b0;
    end else if (cmd_wr) begin
      op_rd <= cmd_rd_go;
      ack   <= cmd_bad;
      err   <= cmd_bad;
    end else if (busy && state_next == DONE) begin
      ack <= 1'b1;
      if (timeout) err <= 1'b1;
    end
  end

  // RDDATA capture: response data, or the timeout pattern.
  always_ff @(posedge clk) begin
    if (rst)             rddata_reg <= '0;
    else if (rd_capture) rddata_reg <= tc_rdata;
    else if (timeout)    rddata_reg <= TIMEOUT_PATTERN;
  end

  // CSR read port: one-cycle latency, returns pre-write register values.
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_rdata     <= '0;
      csr_rdata_vld <= 1'b0;
    end else begin
      csr_rdata_vld <= csr_rd;
      if (csr_rd) begin
        unique case (csr_addr)
          OFS_CMD:     csr_rdata <= cmd_view;
          OFS_ADDRESS: csr_rdata <= addr_reg;
          OFS_RDDATA:  csr_rdata <= rddata_reg;
          OFS_WRDATA:  csr_rdata <= wdata_reg;
          default:     csr_rdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hssi_mb_responder.sv
// Directed bench for hssi_mb_responder (ADDR_W=16, TIMEOUT_CYCLES=16).
// Timeout scenario is compiled when HSSI_MB_TIMEOUT_EN is defined.
module tb_hssi_mb_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_wr, csr_rd;
  logic [3:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_rdata_vld;
  logic [15:0] tc_addr;
  logic        tc_wr, tc_rd;
  logic [31:0] tc_wdata;
  logic        tc_waitrequest;
  logic [31:0] tc_rdata;
  logic        tc_rdata_vld;

  int errors = 0;
  int checks = 0;
  int wr_accepts = 0;
  int acc_before;
  logic [31:0] rd_val;

  hssi_mb_responder #(.ADDR_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_rdata_vld(csr_rdata_vld),
    .tc_addr(tc_addr), .tc_wr(tc_wr), .tc_rd(tc_rd), .tc_wdata(tc_wdata),
    .tc_waitrequest(tc_waitrequest), .tc_rdata(tc_rdata), .tc_rdata_vld(tc_rdata_vld)
  );

  always #5 clk = ~clk;

  // Count accepted traffic-controller writes.
  always @(posedge clk) if (!rst && tc_wr && !tc_waitrequest) wr_accepts++;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_wr = 1'b1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_wr = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_rd = 1'b1; csr_addr = a;
    @(negedge clk);
    csr_rd = 1'b0;
    check("rdata_vld", {31'b0, csr_rdata_vld}, 32'h1);
    d = csr_rdata;
  endtask

  initial begin
    rst = 1'b1; csr_wr = 1'b0; csr_rd = 1'b0; csr_addr = 4'h0; csr_wdata = '0;
    tc_waitrequest = 1'b0; tc_rdata = '0; tc_rdata_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_tc_wr",   {31'b0, tc_wr}, 32'h0);
    check("rst_tc_rd",   {31'b0, tc_rd}, 32'h0);
    check("rst_tc_addr", {16'b0, tc_addr}, 32'h0);
    check("rst_vld",     {31'b0, csr_rdata_vld}, 32'h0);
    csr_read(4'h0, rd_val); check("rst_cmd", rd_val, 32'h0);
    csr_read(4'h8, rd_val); check("rst_rddata", rd_val, 32'h0);

    // Simple write, no stall
    csr_write(4'h4, 32'h0);
    csr_write(4'hC, 32'h20);
    acc_before = wr_accepts;
    csr_write(4'h0, 32'h2);
    check("w_tc_wr",    {31'b0, tc_wr}, 32'h1);
    check("w_tc_rd",    {31'b0, tc_rd}, 32'h0);
    check("w_tc_addr",  {16'b0, tc_addr}, 32'h0);
    check("w_tc_wdata", tc_wdata, 32'h20);
    @(negedge clk);
    check("w_tc_wr_drop", {31'b0, tc_wr}, 32'h0);
    check("w_accepts", wr_accepts - acc_before, 32'd1);
    csr_read(4'h0, rd_val); check("w_cmd", rd_val, 32'h4);

    // Read, response three cycles after acceptance
    csr_write(4'h4, 32'h101);
    csr_write(4'h0, 32'h1);
    check("r_tc_rd",   {31'b0, tc_rd}, 32'h1);
    check("r_tc_addr", {16'b0, tc_addr}, 32'h101);
    @(negedge clk);
    check("r_tc_rd_drop", {31'b0, tc_rd}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    tc_rdata_vld = 1'b1; tc_rdata = 32'h0000_0020;
    csr_rd = 1'b1; csr_addr = 4'h0;
    @(negedge clk);
    tc_rdata_vld = 1'b0; csr_rd = 1'b0;
    check("r_cmd_at_done", csr_rdata & 32'h1C, 32'h08);
    csr_read(4'h8, rd_val); check("r_rddata", rd_val, 32'h20);
    csr_read(4'h0, rd_val); check("r_cmd", rd_val, 32'h4);

    // Stray response while idle is ignored
    @(negedge clk);
    tc_rdata_vld = 1'b1; tc_rdata = 32'h0BAD;
    @(negedge clk);
    tc_rdata_vld = 1'b0;
    csr_read(4'h8, rd_val); check("stray_rddata", rd_val, 32'h20);

    // Write stalled 5 cycles by waitrequest
    csr_write(4'h4, 32'h1234);
    csr_write(4'hC, 32'hCAFE);
    tc_waitrequest = 1'b1;
    acc_before = wr_accepts;
    csr_write(4'h0, 32'h2);
    for (int i = 0; i < 6; i++) begin
      check("s_tc_wr",   {31'b0, tc_wr}, 32'h1);
      check("s_tc_addr", {16'b0, tc_addr}, 32'h1234);
      if (i == 5) tc_waitrequest = 1'b0;
      @(negedge clk);
    end
    check("s_tc_wr_drop", {31'b0, tc_wr}, 32'h0);
    check("s_accepts", wr_accepts - acc_before, 32'd1);
    csr_read(4'h0, rd_val); check("s_cmd", rd_val, 32'h4);

    // Writes while busy are ignored
    tc_waitrequest = 1'b1;
    csr_write(4'h0, 32'h2);
    csr_write(4'h4, 32'h5);
    csr_write(4'h0, 32'h1);
    csr_read(4'h4, rd_val); check("b_address", rd_val, 32'h1234);
    check("b_tc_addr", {16'b0, tc_addr}, 32'h1234);
    check("b_tc_rd", {31'b0, tc_rd}, 32'h0);
    tc_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b_tc_wr_idle", {31'b0, tc_wr}, 32'h0);
    check("b_tc_rd_idle", {31'b0, tc_rd}, 32'h0);
    csr_read(4'h0, rd_val); check("b_cmd", rd_val, 32'h4);

    // Illegal command 11, then 00
    csr_write(4'h0, 32'h3);
    check("e_tc_wr", {31'b0, tc_wr}, 32'h0);
    check("e_tc_rd", {31'b0, tc_rd}, 32'h0);
    csr_read(4'h0, rd_val); check("e_cmd", rd_val, 32'h14);
    csr_write(4'h0, 32'h0);
    csr_read(4'h0, rd_val); check("z_cmd", rd_val, 32'h0);

    // Simultaneous read/write, unmapped offset, wide ADDRESS
    @(negedge clk);
    csr_wr = 1'b1; csr_rd = 1'b1; csr_addr = 4'hC; csr_wdata = 32'h55;
    @(negedge clk);
    csr_wr = 1'b0; csr_rd = 1'b0;
    check("rw_old", csr_rdata, 32'hCAFE);
    csr_read(4'hC, rd_val); check("rw_new", rd_val, 32'h55);
    csr_read(4'h2, rd_val); check("unmapped", rd_val, 32'h0);
    csr_write(4'h4, 32'hABCD_0101);
    csr_read(4'h4, rd_val); check("addr_wide", rd_val, 32'hABCD_0101);
    check("tc_addr_trunc", {16'b0, tc_addr}, 32'h0101);

`ifdef HSSI_MB_TIMEOUT_EN
    // Read with no response times out after 16 cycles
    csr_write(4'h0, 32'h1);
    repeat (14) @(negedge clk);
    csr_read(4'h0, rd_val); check("t_busy_before", rd_val & 32'h1C, 32'h08);
    repeat (4) @(negedge clk);
    csr_read(4'h8, rd_val); check("t_rddata", rd_val, 32'hDEAD_BEEF);
    csr_read(4'h0, rd_val); check("t_cmd", rd_val, 32'h14);
`else
    // Without timeout, a read waits for its response indefinitely
    csr_write(4'h0, 32'h1);
    repeat (40) @(negedge clk);
    csr_read(4'h0, rd_val); check("n_cmd_wait", rd_val, 32'h08);
    tc_rdata_vld = 1'b1; tc_rdata = 32'h1357;
    @(negedge clk);
    tc_rdata_vld = 1'b0;
    csr_read(4'h8, rd_val); check("n_rddata", rd_val, 32'h1357);
    csr_read(4'h0, rd_val); check("n_cmd", rd_val, 32'h4);
`endif

    // Reset in the middle of a read
    tc_waitrequest = 1'b1;
    csr_write(4'h0, 32'h1);
    check("x_tc_rd", {31'b0, tc_rd}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("x_tc_rd",    {31'b0, tc_rd}, 32'h0);
    check("x_tc_wr",    {31'b0, tc_wr}, 32'h0);
    check("x_tc_addr",  {16'b0, tc_addr}, 32'h0);
    check("x_tc_wdata", tc_wdata, 32'h0);
    check("x_rdata",    csr_rdata, 32'h0);
    check("x_vld",      {31'b0, csr_rdata_vld}, 32'h0);
    tc_waitrequest = 1'b0;
    tc_rdata_vld = 1'b1; tc_rdata = 32'h77;
    @(negedge clk);
    tc_rdata_vld = 1'b0;
    csr_read(4'h8, rd_val); check("x_rddata", rd_val, 32'h0);
    csr_read(4'h0, rd_val); check("x_cmd", rd_val, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
